cnt_core: RTL

//  Hardware counter datapath driven by the counter control-register block.
//  - Consumes enable/clear/threshold from the control registers.
//  - Returns the live count value and the terminal-count status.
//  - Adds a compile-time prescaler, one-shot/auto-reload mode and a 1-cycle event pulse.

---
 rtl/cnt_pkg.sv | 13 +
 rtl/cnt_prescaler.sv | 32 +++
 rtl/cnt_core.sv | 95 +++++++++
 3 files changed

// File: rtl/cnt_pkg.sv
// Shared types and defaults for the counter datapath.
// Holds the FSM state encoding and the default counter width.
package cnt_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_e;

endpackage

// File: rtl/cnt_prescaler.sv
// Prescaler: counts enabled RUN cycles 0..PRESC_DIV-1 and flags the last one.
// Latency: tick_o is combinational from the phase register and run_i; no backpressure.
// Phase is held while run_i is low and cleared by clr_i or reset.
module cnt_prescaler #(
    parameter int PRESC_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESC_DIV - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] presc_q;

    assign tick_o = run_i && (presc_q == LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
        end else if (clr_i) begin
            presc_q <= '0;
        end else if (run_i) begin
            presc_q <= (presc_q == LAST) ? '0 : presc_q + ONE;
        end
    end

endmodule

// File: rtl/cnt_core.sv
// Counter datapath: prescaled up-counter with terminal-count flag and event pulse.
// Latency: val/tc/evt all update on the tick edge; no backpressure, inputs sampled every cycle.
// Clear has top priority over every other event, including a coincident terminal tick.
module cnt_core
    import cnt_pkg::*;
#(
    parameter int W         = CNT_W,
    parameter int PRESC_DIV = 1,
    parameter int ONE_SHOT  = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cnt_en_i,
    input  logic         cnt_clr_i,
    input  logic [W-1:0] cnt_thr_i,
    output logic [W-1:0] cnt_val_o,
    output logic         cnt_tc_o,
    output logic         cnt_evt_o
);

    localparam logic [W-1:0] ONE = W'(1);

    cnt_state_e state_q, state_d;
    logic       run;
    logic       tick;
    logic       term;

    assign run = (state_q == RUN) && cnt_en_i;

    generate
        if (PRESC_DIV == 1) begin : g_no_presc
            assign tick = run;
        end else begin : g_presc
            cnt_prescaler #(
                .PRESC_DIV (PRESC_DIV)
            ) u_presc (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .run_i  (run),
                .clr_i  (cnt_clr_i),
                .tick_o (tick)
            );
        end
    endgenerate

    // >= rather than == so a threshold lowered below the count still terminates.
    assign term = tick && (cnt_val_o >= cnt_thr_i);

    always_comb begin
        state_d = state_q;
        if (cnt_clr_i) begin
            state_d = cnt_en_i ? RUN : IDLE;
        end else begin
            case (state_q)
                IDLE: if (cnt_en_i) state_d = RUN;
                RUN: begin
                    if (!cnt_en_i) begin
                        state_d = IDLE;
                    end else if (term && (ONE_SHOT != 0)) begin
                        state_d = DONE;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_val_o <= '0;
            cnt_tc_o  <= 1'b0;
            cnt_evt_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_evt_o <= 1'b0;
            if (cnt_clr_i) begin
                cnt_val_o <= '0;
                cnt_tc_o  <= 1'b0;
            end else if (tick) begin
                if (term) begin
                    cnt_tc_o  <= 1'b1;
                    cnt_evt_o <= 1'b1;
                    if (ONE_SHOT == 0) begin
                        cnt_val_o <= '0;
                    end
                end else begin
                    cnt_val_o <= cnt_val_o + ONE;
                end
            end
        end
    end

endmodule
